conv_mem_host: RTL and testbench

Synthesizable memory responder for the CONV accelerator's external interface. It is the memory side of the CONV port set. It holds the 64×64 grayscale image ROM and serves `iaddr`/`idata`. It runs the `ready`/`busy` start handshake. It serves `crd`/`cwr`/`csel` accesses to the five layer memories (L0 kernel 0/1, L1 kernel 0/1, L2 flatten). A host side loads the image beforehand and reads results back afterwards. It sits between the on-chip host/bus bridge and the CONV core, and replaces the behavioural memory models for FPGA and emulation runs.

---
 rtl/conv_mem_pkg.sv | 46 ++++
 rtl/conv_mem_bank.sv | 38 +++
 rtl/conv_mem_host.sv | 166 ++++++++++++++++
 tb/tb_conv_mem_host.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_mem_pkg.sv
// Shared constants for the CONV memory responder: data width, bank depths,
// csel encoding, FSM state codes and the csel/address decode helper.
package conv_mem_pkg;

   localparam int DW        = 20;
   localparam int AW        = 12;
   localparam int IMG_DEPTH = 4096;
   localparam int L0_DEPTH  = 4096;
   localparam int L1_DEPTH  = 1024;
   localparam int L2_DEPTH  = 2048;

   localparam logic [2:0] CSEL_L0K0 = 3'd1;
   localparam logic [2:0] CSEL_L0K1 = 3'd2;
   localparam logic [2:0] CSEL_L1K0 = 3'd3;
   localparam logic [2:0] CSEL_L1K1 = 3'd4;
   localparam logic [2:0] CSEL_L2   = 3'd5;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ARM  = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef struct packed {
      logic       valid;
      logic [2:0] idx;     // 0..4 = L0K0, L0K1, L1K0, L1K1, L2
   } bank_hit_t;

   // Maps a csel/address pair onto a layer bank index and flags invalid
   // selects or addresses beyond the selected bank's depth.
   function automatic bank_hit_t bank_decode(input logic [2:0] sel,
                                             input logic [AW-1:0] addr);
      bank_hit_t hit;
      logic [AW:0] ext;
      ext       = {1'b0, addr};
      hit.idx   = sel - 3'd1;
      hit.valid = 1'b0;
      case (sel)
         CSEL_L0K0, CSEL_L0K1: hit.valid = (ext < 13'(L0_DEPTH));
         CSEL_L1K0, CSEL_L1K1: hit.valid = (ext < 13'(L1_DEPTH));
         CSEL_L2:              hit.valid = (ext < 13'(L2_DEPTH));
         default:              hit.valid = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/conv_mem_bank.sv
// DEPTH x DW RAM, one write port and one registered read port.
// Optional build macro CONV_MEM_WR_FWD_EN: a read hitting the address being
// written in the same cycle returns the new data instead of the old contents.
module conv_mem_bank
   import conv_mem_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int BAW   = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           we,
   input  logic [BAW-1:0] waddr,
   input  logic [DW-1:0]  wdata,
   input  logic           re,
   input  logic [BAW-1:0] raddr,
   output logic [DW-1:0]  rdata
);

   logic [DW-1:0] mem [DEPTH];

   // Array write; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Registered read, holds when re is low.
   always_ff @(posedge clk) begin
      if (re) begin
`ifdef CONV_MEM_WR_FWD_EN
         if (we && (waddr == raddr)) rdata <= wdata;
         else                        rdata <= mem[raddr];
`else
         rdata <= mem[raddr];
`endif
      end
   end

endmodule

// File: rtl/conv_mem_host.sv
// Memory responder for the CONV accelerator: image ROM, five layer banks,
// ready/busy start handshake, host image load and result readback.
// Optional build macro CONV_MEM_WR_FWD_EN selects write-through forwarding
// in the layer banks (default: read-before-write).
//
// state | meaning
// IDLE  | host may load image / read back banks; start -> ARM
// ARM   | ready=1, waiting for busy=1
// RUN   | CONV accesses served; busy=0 -> DONE
// DONE  | one-cycle done pulse, back to IDLE
module conv_mem_host
   import conv_mem_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          ld_valid,
   input  logic [11:0]   ld_addr,
   input  logic [DW-1:0] ld_data,
   input  logic          rb_req,
   input  logic [2:0]    rb_sel,
   input  logic [11:0]   rb_addr,
   output logic [DW-1:0] rb_data,
   output logic          done,
   output logic [2:0]    wr_seen,
   output logic          proto_err,
   output logic          ready,
   input  logic          busy,
   input  logic [11:0]   iaddr,
   output logic [DW-1:0] idata,
   input  logic          cwr,
   input  logic [11:0]   caddr_wr,
   input  logic [DW-1:0] cdata_wr,
   input  logic          crd,
   input  logic [11:0]   caddr_rd,
   output logic [DW-1:0] cdata_rd,
   input  logic [2:0]    csel
);

   logic [1:0]    state;
   logic          in_idle, in_run, accept;
   bank_hit_t     wr_hit, rd_hit, rb_hit;
   logic          wr_ok, rd_ok, rb_ok, acc_err;
   logic [4:0]    lwe, lre;
   logic [11:0]   lraddr;
   logic [2:0]    seen_set;
   logic [DW-1:0] lrdata [5];
   logic [DW-1:0] img_rdata;

   logic          idata_vld;
   logic [2:0]    rd_src, rb_src;
   logic          rd_fresh, rb_fresh;
   logic [DW-1:0] cd_hold, rb_hold, cd_new, rb_new;

   assign in_idle = (state == ST_IDLE);
   assign in_run  = (state == ST_RUN);
   assign accept  = in_idle & start;
   assign ready   = (state == ST_ARM);
   assign done    = (state == ST_DONE);

   assign wr_hit  = bank_decode(csel, caddr_wr);
   assign rd_hit  = bank_decode(csel, caddr_rd);
   assign rb_hit  = bank_decode(rb_sel, rb_addr);

   // Writes are additionally gated by reset so an aborted run cannot
   // commit data on the reset edge.
   assign wr_ok   = reset & in_run & cwr & wr_hit.valid;
   assign rd_ok   = in_run & crd & rd_hit.valid;
   assign rb_ok   = in_idle & rb_req & rb_hit.valid;
   assign acc_err = (cwr & ~(in_run & wr_hit.valid)) |
                    (crd & ~(in_run & rd_hit.valid));

   // CONV reads only happen in RUN, readback only in IDLE, so they share
   // the single read port of each layer bank.
   assign lraddr  = in_run ? caddr_rd : rb_addr;

   // Per-bank strobes and the layer "written" flags for this cycle.
   always_comb begin
      lwe      = '0;
      lre      = '0;
      seen_set = '0;
      if (wr_ok) begin
         lwe[wr_hit.idx] = 1'b1;
         case (csel)
            CSEL_L0K0, CSEL_L0K1: seen_set = 3'b001;
            CSEL_L1K0, CSEL_L1K1: seen_set = 3'b010;
            default:              seen_set = 3'b100;
         endcase
      end
      if (rd_ok) lre[rd_hit.idx] = 1'b1;
      if (rb_ok) lre[rb_hit.idx] = 1'b1;
   end

   conv_mem_bank #(.DEPTH(IMG_DEPTH)) u_img (
      .clk(clk), .we(reset & in_idle & ld_valid), .waddr(ld_addr), .wdata(ld_data),
      .re(in_run), .raddr(iaddr), .rdata(img_rdata));

   conv_mem_bank #(.DEPTH(L0_DEPTH)) u_l0k0 (
      .clk(clk), .we(lwe[0]), .waddr(caddr_wr), .wdata(cdata_wr),
      .re(lre[0]), .raddr(lraddr), .rdata(lrdata[0]));

   conv_mem_bank #(.DEPTH(L0_DEPTH)) u_l0k1 (
      .clk(clk), .we(lwe[1]), .waddr(caddr_wr), .wdata(cdata_wr),
      .re(lre[1]), .raddr(lraddr), .rdata(lrdata[1]));

   conv_mem_bank #(.DEPTH(L1_DEPTH)) u_l1k0 (
      .clk(clk), .we(lwe[2]), .waddr(caddr_wr[9:0]), .wdata(cdata_wr),
      .re(lre[2]), .raddr(lraddr[9:0]), .rdata(lrdata[2]));

   conv_mem_bank #(.DEPTH(L1_DEPTH)) u_l1k1 (
      .clk(clk), .we(lwe[3]), .waddr(caddr_wr[9:0]), .wdata(cdata_wr),
      .re(lre[3]), .raddr(lraddr[9:0]), .rdata(lrdata[3]));

   conv_mem_bank #(.DEPTH(L2_DEPTH)) u_l2 (
      .clk(clk), .we(lwe[4]), .waddr(caddr_wr[10:0]), .wdata(cdata_wr),
      .re(lre[4]), .raddr(lraddr[10:0]), .rdata(lrdata[4]));

   // Source select of the last access (0 = forced zero). The bank read
   // registers can be overwritten by the other requester later, so the
   // value seen in the cycle after an access is captured into a hold reg.
   always_comb begin
      cd_new = '0;
      rb_new = '0;
      if (rd_src != 3'd0) cd_new = lrdata[rd_src - 3'd1];
      if (rb_src != 3'd0) rb_new = lrdata[rb_src - 3'd1];
   end

   assign cdata_rd = rd_fresh  ? cd_new    : cd_hold;
   assign rb_data  = rb_fresh  ? rb_new    : rb_hold;
   assign idata    = idata_vld ? img_rdata : '0;

   // Handshake FSM, sticky flags and read-result bookkeeping.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         wr_seen   <= '0;
         proto_err <= 1'b0;
         idata_vld <= 1'b0;
         rd_src    <= '0;
         rd_fresh  <= 1'b0;
         cd_hold   <= '0;
         rb_src    <= '0;
         rb_fresh  <= 1'b0;
         rb_hold   <= '0;
      end else begin
         case (state)
            ST_IDLE: if (start) state <= ST_ARM;
            ST_ARM:  if (busy)  state <= ST_RUN;
            ST_RUN:  if (!busy) state <= ST_DONE;
            default:            state <= ST_IDLE;
         endcase
         idata_vld <= in_run;
         proto_err <= (accept ? 1'b0 : proto_err) | acc_err;
         wr_seen   <= (accept ? 3'b000 : wr_seen) | seen_set;

         if (rd_fresh) cd_hold <= cd_new;
         rd_fresh <= crd;
         if (crd) rd_src <= rd_ok ? csel : 3'd0;

         if (rb_fresh) rb_hold <= rb_new;
         rb_fresh <= in_idle & rb_req;
         if (in_idle & rb_req) rb_src <= rb_ok ? rb_sel : 3'd0;
      end
   end

endmodule

// File: tb/tb_conv_mem_host.sv
// Directed + randomized bench for conv_mem_host with a behavioural memory model.
module tb_conv_mem_host;

   logic        clk = 1'b0;
   logic        reset, start, ld_valid, rb_req, busy, cwr, crd;
   logic [11:0] ld_addr, rb_addr, iaddr, caddr_wr, caddr_rd;
   logic [19:0] ld_data, cdata_wr;
   logic [2:0]  rb_sel, csel;
   logic [19:0] rb_data, idata, cdata_rd;
   logic        done, proto_err, ready;
   logic [2:0]  wr_seen;

   int vectors = 0;
   int miscompares = 0;

   logic [19:0] img_m [4096];
   logic [19:0] lay_m [1:5][4096];
   logic [2:0]  seen_m;
   int          ls[$], la[$];

   always #5 clk = ~clk;

   conv_mem_host dut (
      .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid),
      .ld_addr(ld_addr), .ld_data(ld_data), .rb_req(rb_req), .rb_sel(rb_sel),
      .rb_addr(rb_addr), .rb_data(rb_data), .done(done), .wr_seen(wr_seen),
      .proto_err(proto_err), .ready(ready), .busy(busy), .iaddr(iaddr),
      .idata(idata), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
      .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int depth_of(input int s);
      case (s)
         1, 2:    return 4096;
         3, 4:    return 1024;
         5:       return 2048;
         default: return 0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_write(input int s, input int a, input logic [19:0] d);
      if (depth_of(s) != 0 && a < depth_of(s)) begin
         lay_m[s][a] = d;
         seen_m[(s - 1) / 2] = 1'b1;
      end
   endtask

   initial begin
      logic [19:0] old5, d, keep;
      int s, a, ia;

      reset = 1'b0; start = 0; ld_valid = 0; rb_req = 0; busy = 0; cwr = 0; crd = 0;
      ld_addr = 0; rb_addr = 0; iaddr = 0; caddr_wr = 0; caddr_rd = 0;
      ld_data = 0; cdata_wr = 0; rb_sel = 0; csel = 0;
      seen_m = 3'b000;
      tick(); tick();
      chk("rst_ready", ready, 0);
      chk("rst_idata", idata, 0);
      chk("rst_cdata_rd", cdata_rd, 0);
      chk("rst_rb_data", rb_data, 0);
      chk("rst_done", done, 0);
      chk("rst_wr_seen", wr_seen, 0);
      chk("rst_proto_err", proto_err, 0);
      reset = 1'b1;

      // Image load
      for (int i = 0; i < 4096; i++) begin
         img_m[i] = 20'($urandom);
         ld_valid = 1; ld_addr = 12'(i); ld_data = img_m[i];
         tick();
      end
      ld_valid = 0;

      rb_req = 1; rb_sel = 3'd0; rb_addr = 0;
      tick();
      rb_req = 0;
      chk("rb_invalid_sel", rb_data, 0);
      chk("rb_no_err", proto_err, 0);

      // Launch run 1
      start = 1;
      tick();
      start = 0;
      chk("ready_rise", ready, 1);
      repeat (3) tick();
      chk("ready_hold_arm", ready, 1);
      busy = 1;
      tick();
      chk("ready_fall", ready, 0);
      iaddr = 12'hABC;
      tick();
      chk("idata_abc", idata, img_m[12'hABC]);

      // Random layer write / read-back / hold
      for (int i = 0; i < 25; i++) begin
         s  = int'($urandom_range(1, 5));
         a  = int'($urandom_range(0, depth_of(s) - 1));
         d  = 20'($urandom);
         ia = int'($urandom_range(0, 4095));
         cwr = 1; csel = 3'(s); caddr_wr = 12'(a); cdata_wr = d; iaddr = 12'(ia);
         tick();
         cwr = 0;
         model_write(s, a, d);
         ls.push_back(s); la.push_back(a);
         chk("idata_rand", idata, img_m[ia]);
         crd = 1; caddr_rd = 12'(a);
         tick();
         crd = 0;
         chk("cdata_rand", cdata_rd, lay_m[s][a]);
         tick();
         chk("cdata_hold", cdata_rd, lay_m[s][a]);
      end

      // Directed L1 bank 0 accesses
      cwr = 1; csel = 3'd3; caddr_wr = 12'h3FF; cdata_wr = 20'h12345;
      tick();
      model_write(3, 12'h3FF, 20'h12345);
      caddr_wr = 12'h000; cdata_wr = 20'hAAAAA;
      tick();
      cwr = 0;
      model_write(3, 0, 20'hAAAAA);
      crd = 1; caddr_rd = 12'h3FF;
      tick();
      crd = 0;
      chk("l1k0_3ff", cdata_rd, 20'h12345);
      chk("wr_seen_run1", wr_seen, seen_m);
      chk("no_err_yet", proto_err, 0);

      // Protocol errors
      cwr = 1; csel = 3'd3; caddr_wr = 12'h400; cdata_wr = 20'h55555;
      tick();
      cwr = 0;
      chk("err_oor_write", proto_err, 1);
      crd = 1; csel = 3'd3; caddr_rd = 12'h000;
      tick();
      chk("oor_write_dropped", cdata_rd, 20'hAAAAA);
      caddr_rd = 12'h400;
      tick();
      chk("oor_read_zero", cdata_rd, 0);
      caddr_rd = 12'h000;
      tick();
      csel = 3'd6;
      tick();
      crd = 0;
      chk("bad_csel_zero", cdata_rd, 0);

      // Same-cycle write/read on L2 address 7
      cwr = 1; csel = 3'd5; caddr_wr = 12'd7; cdata_wr = 20'h00001;
      tick();
      model_write(5, 7, 20'h00001);
      crd = 1; caddr_rd = 12'd7; cdata_wr = 20'h00002;
      tick();
      cwr = 0; crd = 0;
`ifdef CONV_MEM_WR_FWD_EN
      chk("same_cycle_rw", cdata_rd, 20'h00002);
`else
      chk("same_cycle_rw", cdata_rd, 20'h00001);
`endif
      model_write(5, 7, 20'h00002);
      crd = 1;
      tick();
      crd = 0;
      chk("after_rw", cdata_rd, 20'h00002);

      // Host load / readback ignored during RUN
      old5 = img_m[5];
      ld_valid = 1; ld_addr = 12'd5; ld_data = ~old5;
      rb_req = 1; rb_sel = 3'd3; rb_addr = 12'h3FF;
      tick();
      ld_valid = 0; rb_req = 0;
      chk("rb_ignored_run", rb_data, 0);
      iaddr = 12'd5;
      tick();
      chk("ld_ignored_run", idata, old5);

      // End of run
      busy = 0;
      tick();
      chk("done_pulse", done, 1);
      tick();
      chk("done_one_cycle", done, 0);
      chk("idata_zero_idle", idata, 0);
      chk("wr_seen_after", wr_seen, seen_m);

      // Readback of everything written
      for (int i = 0; i < ls.size(); i++) begin
         rb_req = 1; rb_sel = 3'(ls[i]); rb_addr = 12'(la[i]);
         tick();
         chk("rb_rand", rb_data, lay_m[ls[i]][la[i]]);
      end
      rb_sel = 3'd3; rb_addr = 12'h3FF;
      tick();
      chk("rb_l1k0_3ff", rb_data, 20'h12345);
      rb_req = 0;
      tick();
      chk("rb_hold", rb_data, 20'h12345);
      rb_req = 1; rb_sel = 3'd4; rb_addr = 12'h400;
      tick();
      rb_sel = 3'd7; rb_addr = 12'h000;
      tick();
      rb_req = 0;
      chk("rb_sel7_zero", rb_data, 0);

      // Run 2: busy already high, error in ARM, reset mid-run
      busy = 1;
      tick();
      chk("busy_idle_no_ready", ready, 0);
      start = 1;
      tick();
      start = 0;
      chk("run2_ready", ready, 1);
      chk("run2_err_clr", proto_err, 0);
      chk("run2_seen_clr", wr_seen, 0);
      seen_m = 3'b000;
      crd = 1; csel = 3'd1; caddr_rd = 12'h000;
      tick();
      crd = 0;
      chk("arm_exit_first", ready, 0);
      chk("crd_outside_run_err", proto_err, 1);
      chk("crd_outside_run_zero", cdata_rd, 0);
      keep = 20'($urandom);
      cwr = 1; csel = 3'd1; caddr_wr = 12'h123; cdata_wr = keep;
      tick();
      cwr = 0;
      model_write(1, 12'h123, keep);
      chk("run2_seen", wr_seen, 3'b001);
      reset = 0;
      tick();
      reset = 1; busy = 0;
      chk("abort_ready", ready, 0);
      chk("abort_seen", wr_seen, 0);
      chk("abort_err", proto_err, 0);
      chk("abort_idata", idata, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("abort_no_done", done, 0);
      end
      rb_req = 1; rb_sel = 3'd1; rb_addr = 12'h123;
      tick();
      rb_req = 0;
      chk("abort_rb_kept", rb_data, lay_m[1][12'h123]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
